keypad_scan_ctrl: RTL and testbench

Scan controller for the 4x4 hexadecimal keypad interface. It drives one keypad column low at a time and synchronises the raw row lines through 2-FF chains. It debounces a detected press, freezes the scan while a key is held, and emits the encoded 4-bit hex code with a single-cycle valid strobe. It sits between the physical keypad pins and the downstream hex output encoder and display logic.

---
 rtl/keypad_pkg.sv | 32 +++
 rtl/keypad_scan_ctrl_sync_2ff.sv | 27 ++
 rtl/keypad_scan_ctrl.sv | 144 ++++++++++++++
 tb/tb_keypad_scan_ctrl.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/keypad_pkg.sv
// Shared types and constants for the 4x4 keypad scanner.
package keypad_pkg;

    typedef enum logic [1:0] {SCAN, DEBOUNCE, HELD, RELEASE} scan_state_t;

    localparam logic [3:0] COL_IDLE = 4'b1110;

    // Indexed by {row[1:0], col[1:0]}
    localparam logic [3:0] KEY_MAP [16] = '{
        4'h1, 4'h2, 4'h3, 4'hA,
        4'h4, 4'h5, 4'h6, 4'hB,
        4'h7, 4'h8, 4'h9, 4'hC,
        4'hE, 4'h0, 4'hF, 4'hD
    };

    function automatic logic one_low(input logic [3:0] v);
        logic [3:0] x;
        x = ~v;
        return (x != 4'd0) && ((x & (x - 4'd1)) == 4'd0);
    endfunction

    // Index of the lowest-numbered low bit; callers ensure at least one is low.
    function automatic logic [1:0] low_idx(input logic [3:0] v);
        logic [1:0] idx;
        idx = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if (!v[i]) idx = 2'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/keypad_scan_ctrl_sync_2ff.sv
// Two-flop synchroniser for asynchronous level inputs.
module sync_2ff #(
    parameter int               WIDTH     = 4,
    parameter logic [WIDTH-1:0] RESET_VAL = '1
) (
    input  logic             clk,
    input  logic             async_reset,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    logic [WIDTH-1:0] meta_q;
    logic [WIDTH-1:0] sync_q;

    always_ff @(posedge clk or posedge async_reset) begin
        if (async_reset) begin
            meta_q <= RESET_VAL;
            sync_q <= RESET_VAL;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/keypad_scan_ctrl.sv
// Column scanner with press/release debounce and single-cycle key strobe.
//   state    | meaning
//   SCAN     | rotate columns, sample rows at end of each dwell
//   DEBOUNCE | column frozen, waiting for the latched row pattern to stay put
//   HELD     | key accepted, waiting for all rows high
//   RELEASE  | counting consecutive all-high cycles before resuming the scan
module keypad_scan_ctrl
    import keypad_pkg::*;
#(
    parameter int SCAN_DWELL      = 1000,
    parameter int DEBOUNCE_CYCLES = 20000
) (
    input  logic       clk,
    input  logic       async_reset,
    input  logic [3:0] row_in,
    output logic [3:0] col_out,
    output logic [3:0] key_code,
    output logic       key_valid,
    output logic       key_held
);

    localparam int DW_W = $clog2(SCAN_DWELL);
    localparam int DB_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [DW_W-1:0] DWELL_LAST = DW_W'(SCAN_DWELL - 1);
    localparam logic [DB_W-1:0] DEB_LAST   = DB_W'(DEBOUNCE_CYCLES - 1);

    logic [3:0]      rows_s;
    scan_state_t     state_q, state_d;
    logic [3:0]      col_q, col_d;
    logic [DW_W-1:0] dwell_q, dwell_d;
    logic [DB_W-1:0] deb_q, deb_d;
    logic [3:0]      pat_q, pat_d;
    logic [1:0]      row_q, row_d;
    logic [3:0]      code_q, code_d;
    logic            valid_q, valid_d;
    logic            held_q, held_d;

    sync_2ff #(.WIDTH(4), .RESET_VAL(4'hF)) u_row_sync (
        .clk         (clk),
        .async_reset (async_reset),
        .d_i         (row_in),
        .q_o         (rows_s)
    );

    always_comb begin
        state_d = state_q;
        col_d   = col_q;
        dwell_d = dwell_q;
        deb_d   = deb_q;
        pat_d   = pat_q;
        row_d   = row_q;
        code_d  = code_q;
        valid_d = 1'b0;
        held_d  = held_q;
        case (state_q)
            SCAN: begin
                if (dwell_q == DWELL_LAST) begin
                    dwell_d = '0;
                    if (one_low(rows_s)) begin
                        pat_d   = rows_s;
                        row_d   = low_idx(rows_s);
                        deb_d   = DB_W'(1);
                        state_d = DEBOUNCE;
                    end else begin
                        col_d = {col_q[2:0], col_q[3]};
                    end
                end else begin
                    dwell_d = dwell_q + DW_W'(1);
                end
            end
            DEBOUNCE: begin
                if (rows_s == pat_q) begin
                    if (deb_q == DEB_LAST) begin
                        deb_d   = '0;
                        code_d  = KEY_MAP[{row_q, low_idx(col_q)}];
                        valid_d = 1'b1;
                        held_d  = 1'b1;
                        state_d = HELD;
                    end else begin
                        deb_d = deb_q + DB_W'(1);
                    end
                end else begin
                    deb_d   = '0;
                    dwell_d = '0;
                    col_d   = {col_q[2:0], col_q[3]};
                    state_d = SCAN;
                end
            end
            HELD: begin
                if (rows_s == 4'hF) begin
                    deb_d   = DB_W'(1);
                    state_d = RELEASE;
                end
            end
            RELEASE: begin
                if (rows_s == 4'hF) begin
                    if (deb_q == DEB_LAST) begin
                        deb_d   = '0;
                        dwell_d = '0;
                        held_d  = 1'b0;
                        col_d   = COL_IDLE;
                        state_d = SCAN;
                    end else begin
                        deb_d = deb_q + DB_W'(1);
                    end
                end else begin
                    deb_d   = '0;
                    state_d = HELD;
                end
            end
            default: state_d = SCAN;
        endcase
    end

    always_ff @(posedge clk or posedge async_reset) begin
        if (async_reset) begin
            state_q <= SCAN;
            col_q   <= COL_IDLE;
            dwell_q <= '0;
            deb_q   <= '0;
            pat_q   <= 4'hF;
            row_q   <= 2'd0;
            code_q  <= 4'h0;
            valid_q <= 1'b0;
            held_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            col_q   <= col_d;
            dwell_q <= dwell_d;
            deb_q   <= deb_d;
            pat_q   <= pat_d;
            row_q   <= row_d;
            code_q  <= code_d;
            valid_q <= valid_d;
            held_q  <= held_d;
        end
    end

    assign col_out   = col_q;
    assign key_code  = code_q;
    assign key_valid = valid_q;
    assign key_held  = held_q;

endmodule

// File: tb/tb_keypad_scan_ctrl.sv
// Bench: a physical keypad matrix model drives the scanner; accepted keys are scored.
module tb_keypad_scan_ctrl;

    localparam int SW = 8;
    localparam int DB = 20;

    logic       clk = 1'b0;
    logic       async_reset = 1'b1;
    logic [3:0] row_in;
    logic [3:0] col_out;
    logic [3:0] key_code;
    logic       key_valid;
    logic       key_held;

    bit         pressed [4][4];
    logic [3:0] key_tab [4][4];
    int         n_checks = 0;
    int         n_fail = 0;
    int         pulse_cnt = 0;
    logic       prev_valid = 1'b0;

    always #5 clk = ~clk;

    keypad_scan_ctrl #(.SCAN_DWELL(SW), .DEBOUNCE_CYCLES(DB)) dut (
        .clk         (clk),
        .async_reset (async_reset),
        .row_in      (row_in),
        .col_out     (col_out),
        .key_code    (key_code),
        .key_valid   (key_valid),
        .key_held    (key_held)
    );

    // A row reads low when any closed switch on it meets a driven-low column.
    always_comb begin
        row_in = 4'hF;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                if (pressed[r][c] && !col_out[c]) row_in[r] = 1'b0;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    always @(posedge clk) begin
        #1;
        check_eq("col_one_low", 32'($countones(~col_out)), 1);
        if (key_valid) begin
            pulse_cnt++;
            check_eq("valid_width", 32'(prev_valid), 0);
        end
        prev_valid = key_valid;
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic release_all();
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++) pressed[r][c] = 1'b0;
    endtask

    task automatic wait_pulse(input string tag, input int base);
        int cyc;
        cyc = 0;
        while (pulse_cnt == base && cyc < 4 * SW + DB + 8) begin
            tick(1);
            cyc++;
        end
        check_eq({tag, "_pulse"}, 32'(pulse_cnt - base), 1);
    endtask

    // Caller sits at a negedge with the final open already applied.
    task automatic time_release(input string tag);
        int edges;
        edges = 0;
        while (key_held && edges < 4 * DB) begin
            @(posedge clk);
            #1;
            edges++;
        end
        check_eq({tag, "_fall"}, 32'(edges), 32'(DB + 2));
        check_eq({tag, "_col"}, 32'(col_out), 32'hE);
        @(negedge clk);
    endtask

    initial begin
        int base, edges, t0, sweep_base;
        int order [16];
        key_tab = '{'{4'h1, 4'h2, 4'h3, 4'hA}, '{4'h4, 4'h5, 4'h6, 4'hB},
                    '{4'h7, 4'h8, 4'h9, 4'hC}, '{4'hE, 4'h0, 4'hF, 4'hD}};

        // Reset values, then exact press latency for key '1' held through reset
        pressed[0][0] = 1'b1;
        tick(3);
        check_eq("rst_col", 32'(col_out), 32'hE);
        check_eq("rst_code", 32'(key_code), 0);
        check_eq("rst_valid", 32'(key_valid), 0);
        check_eq("rst_held", 32'(key_held), 0);
        async_reset = 1'b0;
        edges = 0;
        while (!key_valid && edges < 200) begin
            @(posedge clk);
            #1;
            edges++;
        end
        check_eq("latency_1", 32'(edges), 32'(SW - 1 + DB));
        check_eq("code_1", 32'(key_code), 32'h1);
        @(negedge clk);
        release_all();
        time_release("rel_1");

        // Key '5' held for a long time: one pulse only
        tick($urandom_range(0, 4 * SW));
        base = pulse_cnt;
        pressed[1][1] = 1'b1;
        wait_pulse("k5", base);
        check_eq("k5_code", 32'(key_code), 32'h5);
        tick(3 * DB);
        check_eq("k5_held", 32'(key_held), 1);
        check_eq("k5_single", 32'(pulse_cnt - base), 1);
        release_all();
        time_release("k5_rel");

        // Bouncy press of '5': short closures must never be accepted
        base = pulse_cnt;
        for (int i = 0; i < 8; i++) begin
            pressed[1][1] = 1'b1;
            tick($urandom_range(1, DB / 2 - 1));
            pressed[1][1] = 1'b0;
            tick($urandom_range(1, DB / 2 - 1));
        end
        check_eq("bounce_quiet", 32'(pulse_cnt - base), 0);
        pressed[1][1] = 1'b1;
        wait_pulse("bounce", base);
        check_eq("bounce_code", 32'(key_code), 32'h5);
        release_all();
        time_release("bounce_rel");

        // '#' with a reconnecting bounce inside the release window
        base = pulse_cnt;
        pressed[3][2] = 1'b1;
        wait_pulse("hash", base);
        check_eq("hash_code", 32'(key_code), 32'hF);
        tick(DB);
        pressed[3][2] = 1'b0;
        tick(5);
        pressed[3][2] = 1'b1;
        tick(10);
        check_eq("hash_held_mid", 32'(key_held), 1);
        pressed[3][2] = 1'b0;
        time_release("hash_rel");
        check_eq("hash_single", 32'(pulse_cnt - base), 1);

        // Ghost press: two rows low on column 2 keeps the scan rotating
        base = pulse_cnt;
        pressed[0][2] = 1'b1;
        pressed[1][2] = 1'b1;
        tick(4 * SW);
        edges = 0;
        while (col_out != 4'b1110 && edges < 8 * SW) begin @(posedge clk); #1; edges++; end
        while (col_out == 4'b1110 && edges < 8 * SW) begin @(posedge clk); #1; edges++; end
        t0 = edges;
        while (col_out != 4'b1110 && edges < 16 * SW) begin @(posedge clk); #1; edges++; end
        while (col_out == 4'b1110 && edges < 16 * SW) begin @(posedge clk); #1; edges++; end
        check_eq("ghost_period", 32'(edges - t0), 32'(4 * SW));
        @(negedge clk);
        tick(4 * SW);
        check_eq("ghost_quiet", 32'(pulse_cnt - base), 0);
        release_all();
        tick(SW);

        // Reset mid-HELD with 'A' pressed, then a fresh acceptance
        base = pulse_cnt;
        pressed[0][3] = 1'b1;
        wait_pulse("keyA", base);
        check_eq("keyA_code", 32'(key_code), 32'hA);
        tick(5);
        #2;
        async_reset = 1'b1;
        #1;
        check_eq("midrst_col", 32'(col_out), 32'hE);
        check_eq("midrst_valid", 32'(key_valid), 0);
        check_eq("midrst_held", 32'(key_held), 0);
        check_eq("midrst_code", 32'(key_code), 0);
        tick(2);
        async_reset = 1'b0;
        base = pulse_cnt;
        wait_pulse("keyA2", base);
        check_eq("keyA2_code", 32'(key_code), 32'hA);
        release_all();
        time_release("keyA2_rel");

        // Random-order sweep of all 16 keys
        for (int i = 0; i < 16; i++) order[i] = i;
        for (int i = 15; i > 0; i--) begin
            int j, tmp;
            j = $urandom_range(0, i);
            tmp = order[i];
            order[i] = order[j];
            order[j] = tmp;
        end
        sweep_base = pulse_cnt;
        for (int i = 0; i < 16; i++) begin
            int r, c;
            r = order[i] / 4;
            c = order[i] % 4;
            tick($urandom_range(0, 2 * SW));
            base = pulse_cnt;
            pressed[r][c] = 1'b1;
            wait_pulse("sweep", base);
            check_eq($sformatf("sweep_r%0dc%0d", r, c), 32'(key_code), 32'(key_tab[r][c]));
            tick($urandom_range(0, DB));
            pressed[r][c] = 1'b0;
            tick(DB + $urandom_range(3, SW));
            check_eq("sweep_released", 32'(key_held), 0);
        end
        check_eq("sweep_total", 32'(pulse_cnt - sweep_base), 16);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
